// File: rtl/mem_arb_pkg.sv
// Shared sizing helpers and types for the memory port arbiter.
package mem_arb_pkg;

    localparam int MAX_CH_ID_W = 8;

    typedef logic [MAX_CH_ID_W-1:0] ch_id_t;

    function automatic int ch_id_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int be_w(input int data_width, input int beat_size);
        return data_width / beat_size;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Circular FIFO of channel tags for requests accepted by memory but not yet answered.
module mem_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, request-locking arbiter merging several masters onto one memory port,
// with in-order response routing through a tag FIFO.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BEAT_SIZE       = 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BE_W           = be_w(DATA_WIDTH, BEAT_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_req,
    output logic [NUM_CH-1:0]            ch_grnt,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH-1:0]            ch_ren,
    input  logic [NUM_CH-1:0]            ch_wen,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    input  logic [NUM_CH*BE_W-1:0]       ch_beat,
    output logic [NUM_CH-1:0]            ch_valid,
    output logic [DATA_WIDTH-1:0]        ch_rdata,
    output logic                         mem_req,
    input  logic                         mem_grnt,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_ren,
    output logic                         mem_wen,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [BE_W-1:0]              mem_beat,
    input  logic                         mem_valid,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         err
);

    localparam int CH_ID_W = ch_id_w(NUM_CH);

    logic [CH_ID_W-1:0]  rr_ptr;
    logic                lock;
    logic [CH_ID_W-1:0]  lock_ch;
    logic [CH_ID_W-1:0]  rr_sel;
    logic [CH_ID_W-1:0]  rr_off;
    logic [CH_ID_W:0]    rr_sum;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [CH_ID_W-1:0]  sel;
    logic                accept;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CH_ID_W-1:0]  fifo_head;
    logic                resp_valid;

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit is the winner.
    always_comb begin
        req_dbl = {ch_req, ch_req};
        req_rot = NUM_CH'(req_dbl >> rr_ptr);
        rr_off  = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                rr_off = CH_ID_W'(j);
            end
        end
        rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
        if (rr_sum >= (CH_ID_W + 1)'(NUM_CH)) begin
            rr_sum = rr_sum - (CH_ID_W + 1)'(NUM_CH);
        end
        rr_sel = rr_sum[CH_ID_W-1:0];
    end

    assign sel        = lock ? lock_ch : rr_sel;
    assign mem_req    = (|ch_req) & ~fifo_full & ~rst;
    assign accept     = mem_req & mem_grnt;
    assign resp_valid = mem_valid & ~fifo_empty & ~rst;
    assign ch_rdata   = mem_rdata;

    always_comb begin
        mem_addr  = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_beat  = '0;
        ch_grnt   = '0;
        ch_valid  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == CH_ID_W'(i)) begin
                mem_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_ren   = ch_ren[i];
                mem_wen   = ch_wen[i];
                mem_wdata = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                mem_beat  = ch_beat[i*BE_W +: BE_W];
            end
            ch_grnt[i]  = accept && (sel == CH_ID_W'(i));
            ch_valid[i] = resp_valid && (fifo_head == CH_ID_W'(i));
        end
    end

    // A stalled request freezes the selection so the memory sees stable fields until grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_ch <= '0;
            err     <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (sel == CH_ID_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
                lock   <= 1'b0;
            end else if (mem_req) begin
                lock    <= 1'b1;
                lock_ch <= sel;
            end
            if (mem_valid && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

    mem_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (CH_ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (sel),
        .pop       (resp_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: table-driven round-robin vectors plus hand sequences, with a
// scoreboard queue of expected response channels.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NUM_CH = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BEW    = 4;

    typedef struct {
        logic [1:0]  req;
        logic        grnt;
        logic        mv;
        logic [31:0] rdata;
        logic        exp_req;
        logic [1:0]  exp_grnt;
        int          exp_sel;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_grnt;
    logic [NUM_CH*AW-1:0] ch_addr;
    logic [NUM_CH-1:0]    ch_ren;
    logic [NUM_CH-1:0]    ch_wen;
    logic [NUM_CH*DW-1:0] ch_wdata;
    logic [NUM_CH*BEW-1:0] ch_beat;
    logic [NUM_CH-1:0]    ch_valid;
    logic [DW-1:0]        ch_rdata;
    logic                 mem_req;
    logic                 mem_grnt;
    logic [AW-1:0]        mem_addr;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [DW-1:0]        mem_wdata;
    logic [BEW-1:0]       mem_beat;
    logic                 mem_valid;
    logic [DW-1:0]        mem_rdata;
    logic                 err;

    logic [31:0] addr_v  [NUM_CH];
    logic [31:0] wdata_v [NUM_CH];
    logic [3:0]  beat_v  [NUM_CH];

    int     checks = 0;
    int     errors = 0;
    logic   exp_err = 1'b0;
    ch_id_t sb [$];
    vec_t   rr_tbl [5];

    assign ch_addr  = {addr_v[1], addr_v[0]};
    assign ch_wdata = {wdata_v[1], wdata_v[0]};
    assign ch_beat  = {beat_v[1], beat_v[0]};

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_CH          (NUM_CH),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BEAT_SIZE       (8),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_req    (ch_req),
        .ch_grnt   (ch_grnt),
        .ch_addr   (ch_addr),
        .ch_ren    (ch_ren),
        .ch_wen    (ch_wen),
        .ch_wdata  (ch_wdata),
        .ch_beat   (ch_beat),
        .ch_valid  (ch_valid),
        .ch_rdata  (ch_rdata),
        .mem_req   (mem_req),
        .mem_grnt  (mem_grnt),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_beat  (mem_beat),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic grnt, input logic mv,
                                 input logic [31:0] rdata);
        ch_req    = req;
        mem_grnt  = grnt;
        mem_valid = mv;
        mem_rdata = rdata;
    endtask

    task automatic checkOutput(input logic exp_req, input logic [1:0] exp_grnt, input int exp_sel,
                               input logic mv, input logic [31:0] rdata, input string name);
        logic [1:0] exp_valid;
        logic       err_next;
        ch_id_t     ch;
        exp_valid = 2'b00;
        err_next  = 1'b0;
        check({name, ".mem_req"}, 32'(mem_req), 32'(exp_req));
        check({name, ".ch_grnt"}, 32'(ch_grnt), 32'(exp_grnt));
        if (exp_req) begin
            check({name, ".mem_addr"}, mem_addr, addr_v[exp_sel]);
            check({name, ".mem_ren"}, 32'(mem_ren), 32'(ch_ren[exp_sel]));
            check({name, ".mem_wen"}, 32'(mem_wen), 32'(ch_wen[exp_sel]));
            check({name, ".mem_wdata"}, mem_wdata, wdata_v[exp_sel]);
            check({name, ".mem_beat"}, 32'(mem_beat), 32'(beat_v[exp_sel]));
        end
        if (mv) begin
            if (sb.size() > 0) begin
                ch = sb.pop_front();
                exp_valid[ch[0]] = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end
        check({name, ".ch_valid"}, 32'(ch_valid), 32'(exp_valid));
        if (exp_valid != 2'b00) begin
            check({name, ".ch_rdata"}, ch_rdata, rdata);
        end
        check({name, ".err"}, 32'(err), 32'(exp_err));
        exp_err = exp_err | err_next;
        for (int i = 0; i < NUM_CH; i++) begin
            if (exp_grnt[i]) sb.push_back(ch_id_t'(i));
        end
    endtask

    task automatic runCycle(input logic [1:0] req, input logic grnt, input logic mv,
                            input logic [31:0] rdata, input logic exp_req,
                            input logic [1:0] exp_grnt, input int exp_sel, input string name);
        applyStimulus(req, grnt, mv, rdata);
        @(negedge clk);
        checkOutput(exp_req, exp_grnt, exp_sel, mv, rdata, name);
        @(posedge clk);
        #1;
    endtask

    // Reset asserted mid-cycle with live requests and a response pending; everything must read 0.
    task automatic pulseReset(input string name);
        rst = 1'b1;
        applyStimulus(2'b11, 1'b1, 1'b1, 32'h1234_5678);
        @(negedge clk);
        check({name, ".mem_req"}, 32'(mem_req), 32'd0);
        check({name, ".ch_grnt"}, 32'(ch_grnt), 32'd0);
        check({name, ".ch_valid"}, 32'(ch_valid), 32'd0);
        check({name, ".err"}, 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        sb.delete();
        exp_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        addr_v[0]  = 32'h0000_0100;
        addr_v[1]  = 32'h0000_0200;
        wdata_v[0] = 32'hA5A5_0000;
        wdata_v[1] = 32'h5A5A_1111;
        beat_v[0]  = 4'b1111;
        beat_v[1]  = 4'b0011;
        ch_ren     = 2'b11;
        ch_wen     = 2'b00;
        rst        = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);

        rr_tbl[0] = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 0};
        rr_tbl[1] = '{2'b11, 1'b1, 1'b1, 32'h1111_0000, 1'b1, 2'b10, 1};
        rr_tbl[2] = '{2'b11, 1'b1, 1'b1, 32'h2222_0001, 1'b1, 2'b01, 0};
        rr_tbl[3] = '{2'b11, 1'b1, 1'b1, 32'h3333_0000, 1'b1, 2'b10, 1};
        rr_tbl[4] = '{2'b00, 1'b1, 1'b1, 32'h4444_0001, 1'b0, 2'b00, 0};

        @(posedge clk);
        #1;
        pulseReset("reset");

        $display("[TB] round-robin table");
        for (int v = 0; v < 5; v++) begin
            runCycle(rr_tbl[v].req, rr_tbl[v].grnt, rr_tbl[v].mv, rr_tbl[v].rdata,
                     rr_tbl[v].exp_req, rr_tbl[v].exp_grnt, rr_tbl[v].exp_sel,
                     $sformatf("rr%0d", v));
        end

        $display("[TB] lock while memory stalls");
        runCycle(2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 0, "lk_pre");
        runCycle(2'b00, 1'b0, 1'b1, 32'h0000_0AAA, 1'b0, 2'b00, 0, "lk_rsp");
        runCycle(2'b01, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 0, "lk_st0");
        runCycle(2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 0, "lk_st1");
        runCycle(2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 0, "lk_st2");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 0, "lk_acc");
        runCycle(2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, 1, "lk_nxt");
        runCycle(2'b00, 1'b0, 1'b1, 32'h0000_0B00, 1'b0, 2'b00, 0, "lk_r0");
        runCycle(2'b00, 1'b0, 1'b1, 32'h0000_0B01, 1'b0, 2'b00, 0, "lk_r1");

        $display("[TB] outstanding limit");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 0, "fl_a0");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 1, "fl_a1");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 0, "fl_a2");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 1, "fl_a3");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 0, "fl_blk");
        runCycle(2'b11, 1'b1, 1'b1, 32'h0000_C000, 1'b0, 2'b00, 0, "fl_pop");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 0, "fl_res");
        for (int d = 0; d < 4; d++) begin
            runCycle(2'b00, 1'b0, 1'b1, 32'h0000_D000 + 32'(d), 1'b0, 2'b00, 0,
                     $sformatf("fl_dr%0d", d));
        end

        $display("[TB] read then write routing");
        ch_ren = 2'b10;
        ch_wen = 2'b01;
        runCycle(2'b10, 1'b1, 1'b0, 32'h0,         1'b1, 2'b10, 1, "rw_rd");
        runCycle(2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 0, "rw_wr");
        runCycle(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 0, "rw_r1");
        runCycle(2'b00, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 2'b00, 0, "rw_r0");
        ch_ren = 2'b11;
        ch_wen = 2'b00;

        $display("[TB] stray response");
        runCycle(2'b00, 1'b0, 1'b1, 32'h0000_0E00, 1'b0, 2'b00, 0, "st_rsp");
        runCycle(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 0, "st_hold0");
        runCycle(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 0, "st_hold1");

        $display("[TB] reset with outstanding requests");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 1, "mr_a0");
        runCycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 0, "mr_a1");
        runCycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 0, "mr_a2");
        pulseReset("mr_rst");
        runCycle(2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 0, "mr_first");
        runCycle(2'b00, 1'b0, 1'b1, 32'h0000_0F00, 1'b0, 2'b00, 0, "mr_rsp");
        runCycle(2'b00, 1'b0, 1'b1, 32'h0000_0F01, 1'b0, 2'b00, 0, "mr_stray");
        runCycle(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 0, "mr_err");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
